bubble_sort_core: RTL and testbench

//  Sequential bubble-sort engine behind the BubbleSortIP AXI4-Lite register slave.

---
 rtl/bubble_sort_core.sv | 155 +++++++++++++++
 tb/tb_bubble_sort_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bubble_sort_core.sv
// rtl/bubble_sort_core.sv - sequential bubble-sort engine, one compare/swap per clock
// Build option: define BSORT_SIGNED_EN for two's-complement compare (default unsigned).
module bubble_sort_core #(
  parameter int N      = 4,
  parameter int DATA_W = 32
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic                start,
  input  logic [N*DATA_W-1:0] data_in,
  output logic                busy,
  output logic                done,
  output logic [N*DATA_W-1:0] data_out,
  output logic [15:0]         swap_cnt
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SORT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   arr_q [N];
  logic [DATA_W-1:0]   arr_d [N];
  logic [IDX_W-1:0]    p_q, p_d;
  logic [IDX_W-1:0]    j_q, j_d;
  logic                swapped_q, swapped_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [N*DATA_W-1:0] data_out_q, data_out_d;
  logic [15:0]         swap_cnt_q, swap_cnt_d;

  logic [IDX_W-1:0]    last_j;
  logic [IDX_W-1:0]    j_nx;
  logic [DATA_W-1:0]   elem_a;
  logic [DATA_W-1:0]   elem_b;
  logic                do_swap;

  function automatic logic word_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef BSORT_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Each pass shortens by one: the largest remaining word has bubbled to the top.
  assign last_j  = IDX_W'(N - 2) - p_q;
  assign j_nx    = j_q + IDX_W'(1);
  assign elem_a  = arr_q[j_q];
  assign elem_b  = arr_q[j_nx];
  assign do_swap = word_gt(elem_a, elem_b);

  always_comb begin
    state_d    = state_q;
    arr_d      = arr_q;
    p_d        = p_q;
    j_d        = j_q;
    swapped_d  = swapped_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    swap_cnt_d = swap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < N; k++) begin
            arr_d[k] = data_in[k*DATA_W +: DATA_W];
          end
          p_d       = '0;
          j_d       = '0;
          swapped_d = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_SORT;
        end
      end

      S_SORT: begin
        if (do_swap) begin
          arr_d[j_q]  = elem_b;
          arr_d[j_nx] = elem_a;
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        if (j_q != last_j) begin
          j_d       = j_nx;
          swapped_d = swapped_q | do_swap;
        end else if (!(swapped_q || do_swap) || (p_q == IDX_W'(N - 2))) begin
          // A clean pass means the array is already ordered; stop early.
          state_d = S_DONE;
        end else begin
          p_d       = p_q + IDX_W'(1);
          j_d       = '0;
          swapped_d = 1'b0;
        end
      end

      S_DONE: begin
        for (int k = 0; k < N; k++) begin
          data_out_d[k*DATA_W +: DATA_W] = arr_q[k];
        end
        swap_cnt_d = cnt_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= S_IDLE;
      for (int k = 0; k < N; k++) begin
        arr_q[k] <= '0;
      end
      p_q        <= '0;
      j_q        <= '0;
      swapped_q  <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      swap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      arr_q      <= arr_d;
      p_q        <= p_d;
      j_q        <= j_d;
      swapped_q  <= swapped_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;
  assign swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_bubble_sort_core.sv
// tb/tb_bubble_sort_core.sv - self-checking bench for bubble_sort_core
// Honours BSORT_SIGNED_EN in its reference model and expected tables.
module tb_bubble_sort_core;

  localparam int NW = 4;
  localparam int DW = 32;
  localparam int FW = NW * DW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [FW-1:0] data_in;
  logic          busy;
  logic          done;
  logic [FW-1:0] data_out;
  logic [15:0]   swap_cnt;

  int n_vec;
  int n_err;
  logic [FW-1:0] prev_out;

  bubble_sort_core #(.N(NW), .DATA_W(DW)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .start        (start),
    .data_in      (data_in),
    .busy         (busy),
    .done         (done),
    .data_out     (data_out),
    .swap_cnt     (swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [FW-1:0] din;
    logic [FW-1:0] dout;
    int            swaps;
    int            lat;
  } vec_t;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef BSORT_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Reference: sorted output, swaps = inversion count, passes from max left displacement.
  function automatic void model(input logic [FW-1:0] din, output logic [FW-1:0] dout,
                                output int sw, output int lat);
    logic [DW-1:0] a [NW];
    logic [DW-1:0] s [NW];
    logic [DW-1:0] t;
    int maxl, l, passes, cmp;
    for (int i = 0; i < NW; i++) a[i] = din[i*DW +: DW];
    sw = 0;
    maxl = 0;
    for (int i = 0; i < NW; i++) begin
      l = 0;
      for (int k = 0; k < i; k++) if (gt(a[k], a[i])) l++;
      sw += l;
      if (l > maxl) maxl = l;
    end
    passes = (maxl == 0) ? 1 : ((maxl + 1 < NW - 1) ? maxl + 1 : NW - 1);
    cmp = 0;
    for (int p = 0; p < passes; p++) cmp += NW - 1 - p;
    lat = cmp + 1;
    s = a;
    for (int i = 1; i < NW; i++) begin
      for (int k = i; k > 0 && gt(s[k-1], s[k]); k--) begin
        t = s[k]; s[k] = s[k-1]; s[k-1] = t;
      end
    end
    for (int i = 0; i < NW; i++) dout[i*DW +: DW] = s[i];
  endfunction

  task automatic run_sort(input string name, input logic [FW-1:0] din,
                          input logic [FW-1:0] exp_out, input int exp_sw, input int exp_lat);
    int cyc;
    @(negedge clk);
    data_in = din;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    check({name, " busy_after_start"}, FW'(busy), FW'(1));
    check({name, " out_held"}, data_out, prev_out);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, FW'(cyc), FW'(exp_lat));
    check({name, " busy_at_done"}, FW'(busy), FW'(0));
    check({name, " data_out"}, data_out, exp_out);
    check({name, " swap_cnt"}, FW'(swap_cnt), FW'(exp_sw));
    prev_out = exp_out;
    @(negedge clk);
    check({name, " done_pulse"}, FW'(done), FW'(0));
  endtask

  vec_t tbl [4];
  logic [FW-1:0] rdin, rout;
  int rsw, rlat, cyc, pulses, done_cyc;
  logic [FW-1:0] cap_out;
  logic [15:0] cap_sw;

  initial begin
    n_vec = 0;
    n_err = 0;
    prev_out = '0;
    rst_n = 1'b0;
    start = 1'b0;
    data_in = '0;

    tbl[0] = '{"sorted",  {32'd4, 32'd3, 32'd2, 32'd1}, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 4};
    tbl[1] = '{"reverse", {32'd1, 32'd2, 32'd3, 32'd4}, {32'd4, 32'd3, 32'd2, 32'd1}, 6, 7};
    tbl[2] = '{"dups",    {32'd2, 32'd5, 32'd2, 32'd5}, {32'd5, 32'd5, 32'd2, 32'd2}, 3, 7};
`ifdef BSORT_SIGNED_EN
    tbl[3] = '{"sign",    {32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h1},
                          {32'h7FFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF}, 2, 6};
`else
    tbl[3] = '{"sign",    {32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h1},
                          {32'hFFFFFFFF, 32'h7FFFFFFF, 32'h1, 32'h0}, 3, 7};
`endif

    repeat (3) @(negedge clk);
    check("reset busy", FW'(busy), FW'(0));
    check("reset done", FW'(done), FW'(0));
    check("reset data_out", data_out, '0);
    check("reset swap_cnt", FW'(swap_cnt), FW'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_sort(tbl[i].name, tbl[i].din, tbl[i].dout, tbl[i].swaps, tbl[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      for (int w = 0; w < NW; w++) begin
        rdin[w*DW +: DW] = (i % 2 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom);
      end
      model(rdin, rout, rsw, rlat);
      run_sort($sformatf("rand%0d", i), rdin, rout, rsw, rlat);
    end

    // Start pulse during a sort must be ignored; the second data is already sorted.
    @(negedge clk);
    data_in = {32'd1, 32'd2, 32'd3, 32'd4};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    pulses = 0;
    done_cyc = 0;
    cap_out = '0;
    cap_sw = '0;
    repeat (20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        data_in = {32'd40, 32'd30, 32'd20, 32'd10};
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          done_cyc = cyc;
          cap_out = data_out;
          cap_sw = swap_cnt;
        end
      end
    end
    check("restart pulses", FW'(pulses), FW'(1));
    check("restart latency", FW'(done_cyc), FW'(7));
    check("restart data_out", cap_out, {32'd4, 32'd3, 32'd2, 32'd1});
    check("restart swap_cnt", FW'(cap_sw), FW'(6));
    prev_out = {32'd4, 32'd3, 32'd2, 32'd1};

    // Asynchronous reset in the middle of a sort.
    @(negedge clk);
    data_in = {32'd9, 32'd8, 32'd7, 32'd6};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", FW'(busy), FW'(0));
    check("midrst done", FW'(done), FW'(0));
    check("midrst data_out", data_out, '0);
    check("midrst swap_cnt", FW'(swap_cnt), FW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    prev_out = '0;
    run_sort("after_rst", {32'd2, 32'd5, 32'd2, 32'd5}, {32'd5, 32'd5, 32'd2, 32'd2}, 3, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
